debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-input debouncer: C_CHANNELS independent push-button/switch inputs, each filtered by its own four-state FSM and timer. Each channel produces a debounced level plus single-cycle rise and fall pulses, and the block also produces an aggregate event flag. It sits between board-level mechanical inputs and the application logic, which consumes the pulses directly instead of building its own edge detectors.

---
 rtl/debounce_multi.sv | 133 +++++++++++++
 tb/tb_debounce_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: C_CHANNELS independent push-button/switch debouncers.
// Each channel runs a four-state FSM (ZERO, Z2O, ONE, O2Z) with its own
// timer. A channel's output changes only after the sampled input has held
// the new level for C_TIMERLIM+1 consecutive clocks. Registered one-cycle
// rise/fall pulses accompany every accepted change, and evt_o ORs them all.
// Optional feature macro: DEBOUNCE_MULTI_SYNC_EN inserts a 2-flop
// synchroniser (reset to C_INITVAL) in front of every channel.
module debounce_multi #(
  parameter int                    C_CHANNELS = 4,
  parameter int                    C_CLK_FREQ = 100_000_000,
  parameter int                    C_DEB_FREQ = 1000,
  parameter logic [C_CHANNELS-1:0] C_INITVAL  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [C_CHANNELS-1:0] deb_in_i,
  output logic [C_CHANNELS-1:0] deb_out_o,
  output logic [C_CHANNELS-1:0] rise_o,
  output logic [C_CHANNELS-1:0] fall_o,
  output logic                  evt_o
);

  localparam int C_TIMERLIM = C_CLK_FREQ / C_DEB_FREQ;
  localparam int C_TW       = $clog2(C_TIMERLIM);
  localparam logic [C_TW-1:0] C_TMAX = C_TW'(C_TIMERLIM - 1);

  // Reject configurations that cannot work before any hardware is built.
  if (C_TIMERLIM < 2) begin : g_bad_timerlim
    $error("debounce_multi: C_CLK_FREQ/C_DEB_FREQ must be at least 2");
  end
  if (C_CHANNELS < 1 || C_CHANNELS > 32) begin : g_bad_channels
    $error("debounce_multi: C_CHANNELS must be in 1..32");
  end

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    Z2O  = 2'b01,
    ONE  = 2'b11,
    O2Z  = 2'b10
  } state_t;

  logic [C_CHANNELS-1:0] s;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [C_CHANNELS-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser, parked at the reset level so no false edge follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= C_INITVAL;
      sync2_q <= C_INITVAL;
    end else begin
      // NOTE: non-blocking assignments let sync2_q take the old sync1_q, forming a real 2-stage chain.
      sync1_q <= deb_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = deb_in_i;
`endif

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
    localparam state_t RST_STATE = C_INITVAL[i] ? ONE : ZERO;

    state_t          state_q, state_d;
    logic [C_TW-1:0] timer_q, timer_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // Next-state, timer and pulse decode; s=0/1 reversal outranks timer expiry.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      timer_d = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ZERO: begin
          if (s[i]) state_d = Z2O;
        end
        Z2O: begin
          if (!s[i]) begin
            state_d = ZERO;
          end else if (timer_q == C_TMAX) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ONE: begin
          if (!s[i]) state_d = O2Z;
        end
        O2Z: begin
          if (s[i]) begin
            state_d = ONE;
          end else if (timer_q == C_TMAX) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = RST_STATE;
      endcase
    end

    // State, timer and pulse registers; reset aborts any transition in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= RST_STATE;
        timer_q <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Level decoded straight from the state register, so it cannot glitch.
    assign deb_out_o[i] = (state_q == ONE) || (state_q == O2Z);
    assign rise_o[i]    = rise_q;
    assign fall_o[i]    = fall_q;
  end

  assign evt_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed steps (reset, press, bounce, release,
// simultaneous, limit race, async reset) followed by random input traffic,
// all compared against a run-length reference model of the debounce rule.
module tb_debounce_multi;

  localparam int         CH   = 4;
  localparam int         LIM  = 10;
  localparam logic [3:0] INIT = 4'b0100;
`ifdef DEBOUNCE_MULTI_SYNC_EN
  localparam int         LAT  = LIM + 3;
`else
  localparam int         LAT  = LIM + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] deb_out, rise, fall;
  logic       evt;

  always #5 clk = ~clk;

  debounce_multi #(
    .C_CHANNELS (CH),
    .C_CLK_FREQ (1000),
    .C_DEB_FREQ (100),
    .C_INITVAL  (INIT)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .deb_in_i  (din),
    .deb_out_o (deb_out),
    .rise_o    (rise),
    .fall_o    (fall),
    .evt_o     (evt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a channel's level flips once the sample has differed
  // from it for LIM+1 consecutive clocks; the pulse shows the next cycle.
  logic [3:0] m_lvl, m_rise, m_fall, sq1, sq2, cur;
  int         run [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl  = INIT;
    m_rise = '0;
    m_fall = '0;
    sq1    = INIT;
    sq2    = INIT;
    for (int i = 0; i < CH; i++) run[i] = 0;
  endtask

  task automatic model_update(input logic [3:0] d);
    logic [3:0] smp;
`ifdef DEBOUNCE_MULTI_SYNC_EN
    smp = sq2;
    sq2 = sq1;
    sq1 = d;
`else
    smp = d;
`endif
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < CH; i++) begin
      if (smp[i] != m_lvl[i]) run[i]++;
      else                    run[i] = 0;
      if (run[i] == LIM + 1) begin
        m_lvl[i] = smp[i];
        run[i]   = 0;
        if (smp[i]) m_rise[i] = 1'b1;
        else        m_fall[i] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check("m_deb_out", deb_out, m_lvl);
    check("m_rise",    rise,    m_rise);
    check("m_fall",    fall,    m_fall);
    check("m_evt",     evt,     |(m_rise | m_fall));
  endtask

  // Drive one input vector for one clock, then compare on the falling edge.
  task automatic tick(input logic [3:0] v);
    cur = v;
    din = v;
    @(posedge clk);
    model_update(v);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst_n = 1'b0;
    din   = INIT;
    cur   = INIT;
    model_reset();

    // Reset state held, then released.
    repeat (3) @(negedge clk);
    check("rst_deb_out", deb_out, 4'b0100);
    check("rst_rise",    rise,    4'b0000);
    check("rst_fall",    fall,    4'b0000);
    check("rst_evt",     evt,     1'b0);
    rst_n = 1'b1;
    repeat (3) tick(INIT);
    check("post_rst_deb_out", deb_out, 4'b0100);

    // Clean press on ch0: rise exactly LAT cycles after the first 1.
    for (int n = 1; n <= LAT + 1; n++) begin
      tick(cur | 4'b0001);
      check("press_out",  deb_out[0], n >= LAT);
      check("press_rise", rise[0],    n == LAT);
    end
    repeat (3) tick(cur);

    // Async reset mid-count on ch1: outputs return to INIT before any edge.
    repeat (5) tick(cur | 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("arst_deb_out", deb_out, 4'b0100);
    check("arst_rise",    rise,    4'b0000);
    check("arst_fall",    fall,    4'b0000);
    check("arst_evt",     evt,     1'b0);
    model_reset();
    din = INIT;
    cur = INIT;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick(INIT);

    // Bounce on ch1: 5 high, 2 low, then held; rise LAT after the final 1.
    repeat (5) begin
      tick(cur | 4'b0010);
      check("bounce_quiet", rise[1], 1'b0);
    end
    repeat (2) begin
      tick(cur & 4'b1101);
      check("bounce_quiet", rise[1], 1'b0);
    end
    for (int n = 1; n <= LAT + 1; n++) begin
      tick(cur | 4'b0010);
      check("bounce_rise", rise[1], n == LAT);
    end

    // Init-high ch2: a LIM-cycle low pulse is ignored.
    repeat (LIM) begin
      tick(cur & 4'b1011);
      check("short_low_out", deb_out[2], 1'b1);
    end
    repeat (LAT + 2) begin
      tick(cur | 4'b0100);
      check("short_low_fall", fall[2], 1'b0);
    end

    // Real release on ch2: fall and low level exactly LAT cycles later.
    for (int n = 1; n <= LAT + 1; n++) begin
      tick(cur & 4'b1011);
      check("release_out",  deb_out[2], n < LAT);
      check("release_fall", fall[2],    n == LAT);
    end

    // Bring ch0 low again, then raise ch0 and ch3 together.
    repeat (LAT + 2) tick(cur & 4'b1110);
    for (int n = 1; n <= LAT + 1; n++) begin
      tick(cur | 4'b1001);
      check("simul_rise", rise, (n == LAT) ? 4'b1001 : 4'b0000);
      check("simul_evt",  evt,  n == LAT);
    end

    // Limit race on ch3: s drops back in the cycle the timer reaches LIM-1.
    repeat (LIM) tick(cur & 4'b0111);
    repeat (LAT + 2) begin
      tick(cur | 4'b1000);
      check("race_out",  deb_out[3], 1'b1);
      check("race_fall", fall[3],    1'b0);
    end

    // Random traffic with runs long enough to cross the threshold.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] v;
      v = cur;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
      tick(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
